// File: rtl/muldiv_ctrl_pkg.sv
// Shared types and defaults for the HI/LO multiply/divide controller.
package muldiv_ctrl_pkg;

  typedef logic [31:0] word_t;
  typedef logic [63:0] dword_t;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DIV_BUSY = 2'd1,
    MUL_BUSY = 2'd2,
    DONE     = 2'd3
  } muldiv_state_t;

  localparam int DIV_LATENCY_DEFAULT = 32;
  localparam int MUL_LATENCY_DEFAULT = 2;

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage op/operand bus plus divider wrapper handshake for muldiv_ctrl.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic       op_valid;
  muldiv_op_t op;
  word_t      src_a;
  word_t      src_b;
  logic       flush;
  logic       stall;
  logic       div_valid;
  word_t      div_a;
  word_t      div_b;
  logic       div_signed;
  word_t      div_hi;
  word_t      div_lo;
  word_t      hi_out;
  word_t      lo_out;

  modport slave (
    input  op_valid, op, src_a, src_b, flush, div_hi, div_lo,
    output stall, div_valid, div_a, div_b, div_signed, hi_out, lo_out
  );

  modport master (
    output op_valid, op, src_a, src_b, flush, div_hi, div_lo,
    input  stall, div_valid, div_a, div_b, div_signed, hi_out, lo_out
  );

endinterface

// File: rtl/muldiv_ctrl_mult_pipe.sv
// LATENCY-stage signed/unsigned 32x32->64 multiplier; product of the inputs
// sampled at one edge appears on p_o LATENCY cycles later.
module muldiv_ctrl_mult_pipe
  import muldiv_ctrl_pkg::*;
#(
  parameter int LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic   clk,
  input  logic   reset,
  input  word_t  a_i,
  input  word_t  b_i,
  input  logic   signed_i,
  output dword_t p_o
);

  // Extending straight to 64 bits gives the same low 64 product bits as a 33x33 multiply.
  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  dword_t             pipe_q [LATENCY];

  assign a_ext = {{32{signed_i & a_i[31]}}, a_i};
  assign b_ext = {{32{signed_i & b_i[31]}}, b_i};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= a_ext * b_ext;
      for (int i = 1; i < LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign p_o = pipe_q[LATENCY-1];

endmodule

// File: rtl/muldiv_ctrl.sv
// Execute-stage HI/LO controller: external divider handshake, internal multiplier, MTHI/MTLO.
// Define HILO_FORWARD_EN to bypass the value being written onto hi_out/lo_out in the same cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DEFAULT,
  parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  muldiv_state_t state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  word_t         hi_q, hi_d, lo_q, lo_d;
  logic          hi_we, lo_we;
  logic          div_valid_q, div_valid_d;
  word_t         div_a_q, div_b_q;
  logic          div_signed_q, is_div_q;
  logic          div_issue, mul_issue, stall;
  dword_t        product;
  word_t         res_hi, res_lo;

  muldiv_ctrl_mult_pipe #(.LATENCY(MUL_LATENCY)) u_mult (
    .clk      (clk),
    .reset    (reset),
    .a_i      (bus.src_a),
    .b_i      (bus.src_b),
    .signed_i (bus.op == MULT),
    .p_o      (product)
  );

  assign res_hi = is_div_q ? bus.div_hi : product[63:32];
  assign res_lo = is_div_q ? bus.div_lo : product[31:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    hi_we       = 1'b0;
    lo_we       = 1'b0;
    div_valid_d = div_valid_q;
    div_issue   = 1'b0;
    mul_issue   = 1'b0;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.op_valid && !bus.flush) begin
          case (bus.op)
            MTHI: begin
              hi_we = 1'b1;
              hi_d  = bus.src_a;
            end
            MTLO: begin
              lo_we = 1'b1;
              lo_d  = bus.src_a;
            end
            MULT, MULTU: begin
              stall     = 1'b1;
              mul_issue = 1'b1;
              state_d   = MUL_BUSY;
              cnt_d     = 16'(MUL_LATENCY - 1);
            end
            DIV, DIVU: begin
              stall       = 1'b1;
              div_issue   = 1'b1;
              div_valid_d = 1'b1;
              state_d     = DIV_BUSY;
              cnt_d       = 16'(DIV_LATENCY - 1);
            end
            default: ;
          endcase
        end
      end
      DIV_BUSY, MUL_BUSY: begin
        if (bus.flush) begin
          state_d     = IDLE;
          div_valid_d = 1'b0;
        end else begin
          stall = 1'b1;
          if (cnt_q == 16'd1) state_d = DONE;
          else                cnt_d   = cnt_q - 16'd1;
        end
      end
      DONE: begin
        state_d     = IDLE;
        div_valid_d = 1'b0;
        // A divide by zero still runs full latency but leaves HI/LO alone.
        if (!bus.flush && !(is_div_q && div_b_q == '0)) begin
          hi_we = 1'b1;
          lo_we = 1'b1;
          hi_d  = res_hi;
          lo_d  = res_lo;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      div_valid_q  <= 1'b0;
      div_a_q      <= '0;
      div_b_q      <= '0;
      div_signed_q <= 1'b0;
      is_div_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_valid_q <= div_valid_d;
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
      if (div_issue) begin
        div_a_q      <= bus.src_a;
        div_b_q      <= bus.src_b;
        div_signed_q <= (bus.op == DIV);
      end
      if (div_issue || mul_issue) is_div_q <= div_issue;
    end
  end

  assign bus.stall      = stall;
  assign bus.div_valid  = div_valid_q;
  assign bus.div_a      = div_a_q;
  assign bus.div_b      = div_b_q;
  assign bus.div_signed = div_signed_q;

`ifdef HILO_FORWARD_EN
  assign bus.hi_out = hi_we ? hi_d : hi_q;
  assign bus.lo_out = lo_we ? lo_d : lo_q;
`else
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
`endif

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized ops against an arithmetic HI/LO reference model.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  localparam int DIV_LAT = 32;
  localparam int MUL_LAT = 2;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    assertions = 0;
  int    failures   = 0;
  int    dv_cnt     = 0;
  word_t m_hi = '0;
  word_t m_lo = '0;

  muldiv_ctrl_if bus ();

  muldiv_ctrl #(.DIV_LATENCY(DIV_LAT), .MUL_LATENCY(MUL_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Divider wrapper model: result only valid once div_valid has been held DIV_LAT cycles.
  always @(posedge clk) dv_cnt <= bus.div_valid ? dv_cnt + 1 : 0;

  always_comb begin
    bus.div_hi = 32'hDEAD_BEEF;
    bus.div_lo = 32'hDEAD_BEEF;
    if (bus.div_valid && dv_cnt >= DIV_LAT - 1 && bus.div_b != '0) begin
      if (bus.div_signed) begin
        bus.div_lo = word_t'($signed(bus.div_a) / $signed(bus.div_b));
        bus.div_hi = word_t'($signed(bus.div_a) % $signed(bus.div_b));
      end else begin
        bus.div_lo = bus.div_a / bus.div_b;
        bus.div_hi = bus.div_a % bus.div_b;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int model_stall(input muldiv_op_t op);
    case (op)
      MULT, MULTU: return MUL_LAT;
      DIV, DIVU:   return DIV_LAT;
      default:     return 0;
    endcase
  endfunction

  function automatic void model_exec(input muldiv_op_t op, input word_t a, input word_t b,
                                     inout word_t hi, inout word_t lo);
    longint          sp;
    longint unsigned up;
    int              sa, sb;
    sa = a;
    sb = b;
    case (op)
      MULT:  begin sp = longint'(sa) * longint'(sb); hi = sp[63:32]; lo = sp[31:0]; end
      MULTU: begin up = {32'd0, a} * {32'd0, b};     hi = up[63:32]; lo = up[31:0]; end
      DIV:   if (sb != 0) begin lo = word_t'(sa / sb); hi = word_t'(sa % sb); end
      DIVU:  if (b != '0) begin lo = a / b; hi = a % b; end
      MTHI:  hi = a;
      MTLO:  lo = a;
      default: ;
    endcase
  endfunction

  // Presents an op at a negedge, holds it while stalled, returns one cycle after completion.
  task automatic run_op(input muldiv_op_t op, input word_t a, input word_t b,
                        output int stalls, output int dv_cycles, output bit sign_bad, output bit done);
    stalls    = 0;
    dv_cycles = 0;
    sign_bad  = 1'b0;
    done      = 1'b0;
    bus.op_valid = 1'b1;
    bus.op       = op;
    bus.src_a    = a;
    bus.src_b    = b;
    for (int c = 0; c < 4 * DIV_LAT; c++) begin
      #1;
      if (bus.div_valid) begin
        dv_cycles++;
        if (bus.div_signed !== (op == DIV)) sign_bad = 1'b1;
      end
      if (!bus.stall) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    @(negedge clk);
    bus.op_valid = 1'b0;
    bus.op       = NOP;
    #1;
    $display("op %-5s a=%08h b=%08h stalls=%0d div_valid_cycles=%0d hi=%08h lo=%08h",
             op.name(), a, b, stalls, dv_cycles, bus.hi_out, bus.lo_out);
  endtask

  task automatic run_checked(input string tag, input muldiv_op_t op, input word_t a, input word_t b,
                             input int exp_stall, input word_t exp_hi, input word_t exp_lo);
    int stalls, dv_cycles;
    bit sign_bad, done;
    run_op(op, a, b, stalls, dv_cycles, sign_bad, done);
    check({tag, " completed"}, done, 1);
    check({tag, " stall cycles"}, stalls, exp_stall);
    check({tag, " hi"}, bus.hi_out, exp_hi);
    check({tag, " lo"}, bus.lo_out, exp_lo);
    if (op == DIV || op == DIVU) begin
      check({tag, " div_valid cycles"}, dv_cycles, DIV_LAT);
      check({tag, " div_signed"}, sign_bad, 0);
    end else begin
      check({tag, " div_valid cycles"}, dv_cycles, 0);
    end
    m_hi = exp_hi;
    m_lo = exp_lo;
  endtask

  typedef struct {
    muldiv_op_t op;
    word_t      a;
    word_t      b;
    int         exp_stall;
    word_t      exp_hi;
    word_t      exp_lo;
  } vec_t;

  vec_t       vecs [4];
  muldiv_op_t ops  [7];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    muldiv_op_t r_op;
    word_t      r_a, r_b, e_hi, e_lo;

    vecs[0] = '{DIVU,  32'd100,        32'd7, 32, 32'd2,        32'd14};
    vecs[1] = '{DIV,   32'hFFFF_FFF9,  32'd2, 32, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[2] = '{MULT,  32'hFFFF_FFFD,  32'd5, 2,  32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vecs[3] = '{MULTU, 32'hFFFF_FFFD,  32'd5, 2,  32'h0000_0004, 32'hFFFF_FFF1};
    ops = '{NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO};

    bus.op_valid = 1'b0;
    bus.op       = NOP;
    bus.src_a    = '0;
    bus.src_b    = '0;
    bus.flush    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("reset stall", bus.stall, 0);
    check("reset hi", bus.hi_out, 0);
    check("reset lo", bus.lo_out, 0);
    check("reset div_valid", bus.div_valid, 0);
    check("reset div_a", bus.div_a, 0);
    check("reset div_b", bus.div_b, 0);
    check("reset div_signed", bus.div_signed, 0);
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_checked($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                  vecs[i].exp_stall, vecs[i].exp_hi, vecs[i].exp_lo);

    // MTHI then MTLO back to back, no stall.
    bus.op_valid = 1'b1; bus.op = MTHI; bus.src_a = 32'h1234; bus.src_b = '0;
    #1;
    check("mthi stall", bus.stall, 0);
    @(negedge clk);
    bus.op = MTLO; bus.src_a = 32'h5678;
    #1;
    check("mtlo stall", bus.stall, 0);
    check("mthi hi", bus.hi_out, 32'h1234);
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = NOP;
    #1;
    check("mtlo lo", bus.lo_out, 32'h5678);
    check("mtlo hi kept", bus.hi_out, 32'h1234);
    m_hi = 32'h1234;
    m_lo = 32'h5678;
    $display("seq mthi/mtlo hi=%08h lo=%08h", bus.hi_out, bus.lo_out);

    // MTHI presented together with flush is dropped.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = MTHI; bus.src_a = 32'hAAAA_5555; bus.flush = 1'b1;
    @(negedge clk);
    bus.op_valid = 1'b0; bus.op = NOP; bus.flush = 1'b0;
    #1;
    check("flushed mthi hi", bus.hi_out, m_hi);
    $display("seq flushed mthi hi=%08h", bus.hi_out);

    // DIVU flushed at T0+10, MULT issued at T0+11.
    @(negedge clk);
    bus.op_valid = 1'b1; bus.op = DIVU; bus.src_a = 32'd50; bus.src_b = 32'd3;
    #1;
    check("flush-divu issue stall", bus.stall, 1);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush cycle stall", bus.stall, 0);
    @(negedge clk);
    bus.flush = 1'b0;
    #1;
    check("div_valid after flush", bus.div_valid, 0);
    check("flush hi unchanged", bus.hi_out, m_hi);
    check("flush lo unchanged", bus.lo_out, m_lo);
    $display("seq divu flushed at T0+10 div_valid=%0b", bus.div_valid);
    run_checked("mult after flush", MULT, 32'd6, 32'd7, MUL_LAT, 32'd0, 32'd42);

    // Divide by zero leaves HI/LO; then reset lands mid-DIVU.
    run_checked("div by zero", DIV, 32'd5, 32'd0, DIV_LAT, m_hi, m_lo);
    bus.op_valid = 1'b1; bus.op = DIVU; bus.src_a = 32'd9; bus.src_b = 32'd4;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.op_valid = 1'b0; bus.op = NOP;
    #1;
    check("midop reset hi", bus.hi_out, 0);
    check("midop reset lo", bus.lo_out, 0);
    check("midop reset stall", bus.stall, 0);
    check("midop reset div_valid", bus.div_valid, 0);
    $display("seq reset during divu hi=%08h lo=%08h", bus.hi_out, bus.lo_out);
    m_hi = '0;
    m_lo = '0;
    @(negedge clk);
    run_checked("multu after reset", MULTU, 32'd2, 32'd3, MUL_LAT, 32'd0, 32'd6);

    // Randomized ops against the arithmetic model.
    for (int i = 0; i < 30; i++) begin
      r_op = ops[$urandom_range(0, 6)];
      r_a  = $urandom;
      r_b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if (r_op == DIV && r_a == 32'h8000_0000 && r_b == 32'hFFFF_FFFF) r_b = 32'd1;
      e_hi = m_hi;
      e_lo = m_lo;
      model_exec(r_op, r_a, r_b, e_hi, e_lo);
      run_checked($sformatf("rand%0d", i), r_op, r_a, r_b, model_stall(r_op), e_hi, e_lo);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
